bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset, clk and rst, with the ports listed below.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: number of ACCESS cycles without fc_bus before an error response.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  core requests a transaction.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_mask  input  4  byte-lane mask.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  read data, valid with resp_valid.
REQ-013 resp_err  output  1  timeout error, valid with resp_valid.
REQ-014 addr_bus  output  32  bus address.
REQ-015 data_bus  inout  32  shared data bus.
REQ-016 rd_bus, wr_bus  output  1 each  read/write strobes.
REQ-017 data_mask_bus  output  4  byte-lane mask.
REQ-018 fc_bus  input  1  function-complete from the responder; tri-stated when no responder is hit.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCESS, RELEASE.
REQ-020 req_ready SHALL be 1 only in IDLE; a transfer occurs on a clock edge where req_valid && req_ready.
REQ-021 On a transfer, the block SHALL latch write, addr, wdata and mask and enter ACCESS on the next cycle.
REQ-022 In ACCESS, the block SHALL drive addr_bus and data_mask_bus from the latched values and assert exactly one of rd_bus or wr_bus.
REQ-023 The block SHALL drive data_bus with latched wdata only in ACCESS on writes; otherwise data_bus SHALL be high-impedance.
REQ-024 fc_bus SHALL count as complete only when it is exactly 1; z, x and 0 SHALL all mean not complete.
REQ-025 On an edge in ACCESS with fc_bus complete, the block SHALL capture data_bus into resp_rdata (reads) or 0 (writes), clear resp_err, pulse resp_valid for the following cycle, and enter RELEASE.
REQ-026 In RELEASE, rd_bus and wr_bus SHALL both be 0 for exactly one cycle, so responder write-ack state clears; the block SHALL then enter IDLE.
REQ-027 Outside ACCESS, addr_bus and data_mask_bus SHALL be 0.
REQ-028 Minimum transaction latency SHALL be 3 cycles from accept to next req_ready: ACCESS, RELEASE, IDLE.
REQ-029 A req_valid held during ACCESS or RELEASE SHALL be ignored until IDLE; back-to-back requests SHALL always be separated by a RELEASE cycle.
REQ-030 resp_rdata SHALL hold its last value between responses.

Reset
REQ-031 While rst is high, the block SHALL be in IDLE, with req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, rd_bus=0, wr_bus=0, addr_bus=0, data_mask_bus=0 and data_bus at z.
REQ-032 A reset during ACCESS SHALL immediately release all bus outputs, produce no response, and discard the in-flight request.

Configuration
REQ-033 With BUS_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; when it reaches TIMEOUT_CYCLES without completion, the block SHALL pulse resp_valid with resp_err=1 and resp_rdata=0, then enter RELEASE.
REQ-034 Completion and timeout on the same edge SHALL resolve as completion.
REQ-035 Without BUS_TIMEOUT_EN, ACCESS SHALL wait indefinitely, resp_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-036 The shared package SHALL hold the state encoding (IDLE/ACCESS/RELEASE) and the idle bus values (zero address, zero mask).
REQ-037 The timeout counter SHALL be the single sub-module, bus_timeout_counter (inputs clear/enable, output expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-038 Read from address 0x4 of a responder model returning 0x12345678 with fc after 2 cycles -> rd_bus high 3 cycles; resp_valid pulse with rdata=0x12345678 and err=0; RELEASE cycle with rd_bus=0.
REQ-039 Write of 0x000000FF, mask 0x1, address 0x0 -> wr_bus high and data_bus=0x000000FF until fc; resp_valid with err=0; data_bus returns to z in RELEASE.
REQ-040 Two back-to-back reads with req_valid held high -> wr_bus/rd_bus low for one cycle between them; exactly 2 resp_valid pulses.
REQ-041 Access to an unmapped address, fc_bus=z, BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 -> resp_valid with err=1 and rdata=0 on the 8th ACCESS cycle, then IDLE.
REQ-042 rst asserted on the 2nd ACCESS cycle of a write -> wr_bus=0 and data_bus=z immediately; no resp_valid; req_ready=1 on the first cycle after rst deasserts.
REQ-043 fc_bus=1 and timeout expiring on the same edge -> resp_err=0 and the captured read data returned.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the bus_initiator block: FSM state encoding,
// idle bus values and the function-complete qualifier.
package bus_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;
    localparam logic [3:0]  IDLE_MASK = 4'h0;
    localparam logic [31:0] ZERO_DATA = 32'h0000_0000;

    // A floating or unknown function-complete line never counts as done.
    function automatic logic fc_complete(input logic fc);
        return (fc === 1'b1);
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake and responder-side bus signals of bus_initiator.
// The shared data_bus net is a plain inout on the block so it resolves at the pin.
interface bus_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] addr_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;
    logic        fc_bus;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_mask,
        input  fc_bus,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output addr_bus,
        output rd_bus,
        output wr_bus,
        output data_mask_bus
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_mask,
        output fc_bus,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  addr_bus,
        input  rd_bus,
        input  wr_bus,
        input  data_mask_bus
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// ACCESS-cycle counter for bus_initiator; expired is high during the
// LIMIT-th consecutive enabled cycle. LIMIT must be at least 1.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Counts enabled cycles, parks on the last value until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + ONE;
        end
    end

    assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: IDLE -> ACCESS -> RELEASE.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    bus_initiator_if.master bus,
    inout  wire  [31:0]     data_bus
);

    state_e      state_r;
    state_e      state_s;

    logic        accept_s;
    logic        complete_s;
    logic        timeout_s;
    logic        expired_s;
    logic        access_next_s;

    logic        nxt_write_s;
    logic [31:0] nxt_addr_s;
    logic [3:0]  nxt_mask_s;

    logic        write_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  mask_r;

    logic        rd_bus_r;
    logic        wr_bus_r;
    logic        drive_r;
    logic [31:0] addr_bus_r;
    logic [3:0]  mask_bus_r;

    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;

    // Next-state and transfer-event decode.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_ACCESS;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Completion wins over a timeout landing on the same edge.
                if (fc_complete(bus.fc_bus)) begin
                    complete_s = 1'b1;
                    state_s    = ST_RELEASE;
                end else if (expired_s) begin
                    timeout_s  = 1'b1;
                    state_s    = ST_RELEASE;
                end else begin
                    state_s    = ST_ACCESS;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request fields the bus flops load from on the next edge.
    always_comb begin
        nxt_write_s = write_r;
        nxt_addr_s  = addr_r;
        nxt_mask_s  = mask_r;
        if (accept_s) begin
            nxt_write_s = bus.req_write;
            nxt_addr_s  = bus.req_addr;
            nxt_mask_s  = bus.req_mask;
        end else begin
            nxt_write_s = write_r;
            nxt_addr_s  = addr_r;
            nxt_mask_s  = mask_r;
        end
        access_next_s = (state_s == ST_ACCESS);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched request, loaded only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_r <= 1'b0;
            addr_r  <= IDLE_ADDR;
            wdata_r <= ZERO_DATA;
            mask_r  <= IDLE_MASK;
        end else if (accept_s) begin
            write_r <= bus.req_write;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            mask_r  <= bus.req_mask;
        end
    end

    // Bus-side outputs, active only while the next state is ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bus_r   <= 1'b0;
            wr_bus_r   <= 1'b0;
            drive_r    <= 1'b0;
            addr_bus_r <= IDLE_ADDR;
            mask_bus_r <= IDLE_MASK;
        end else begin
            rd_bus_r   <= access_next_s && !nxt_write_s;
            wr_bus_r   <= access_next_s && nxt_write_s;
            drive_r    <= access_next_s && nxt_write_s;
            addr_bus_r <= access_next_s ? nxt_addr_s : IDLE_ADDR;
            mask_bus_r <= access_next_s ? nxt_mask_s : IDLE_MASK;
        end
    end

    // Response pulse and read-data capture; rdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= ZERO_DATA;
        end else begin
            resp_valid_r <= complete_s || timeout_s;
            if (complete_s) begin
                resp_rdata_r <= write_r ? ZERO_DATA : data_bus;
            end else if (timeout_s) begin
                resp_rdata_r <= ZERO_DATA;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic in_access_s;
    logic resp_err_r;

    assign in_access_s = (state_r == ST_ACCESS);

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_access_s),
        .enable  (in_access_s),
        .expired (expired_s)
    );

    // Error flag follows the kind of the most recent response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_r <= 1'b0;
        end else if (complete_s) begin
            resp_err_r <= 1'b0;
        end else if (timeout_s) begin
            resp_err_r <= 1'b1;
        end
    end

    assign bus.resp_err = resp_err_r;
`else
    logic unused_timeout_cfg_s;

    assign expired_s            = 1'b0;
    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'd0);
    assign bus.resp_err         = 1'b0;
`endif

    assign bus.req_ready     = (state_r == ST_IDLE) && !rst;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_rdata    = resp_rdata_r;
    assign bus.rd_bus        = rd_bus_r;
    assign bus.wr_bus        = wr_bus_r;
    assign bus.addr_bus      = addr_bus_r;
    assign bus.data_mask_bus = mask_bus_r;

    assign data_bus = drive_r ? wdata_r : 32'bz;

endmodule

// File: tb/tb_bus_initiator.sv
// Randomized self-checking bench for bus_initiator with a word-addressed
// responder memory (0x00-0x3F mapped) and a transaction-level expectation model.
module tb_bus_initiator;

    localparam int unsigned TO = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rsp_drive;
    logic [31:0] rsp_data;
    wire  [31:0] data_bus;

    bus_initiator_if bif ();

    assign data_bus = rsp_drive ? rsp_data : 32'bz;

    bus_initiator #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_pulse = 0;
    int          exp_pulse = 0;
    logic [31:0] mem [16];
    logic [31:0] exp_rdata;
    logic [31:0] exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bif.resp_valid === 1'b1) n_pulse++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    // Starts and ends at a negedge in an IDLE cycle.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int lat, input bit keep);
        bit          mapped;
        bit          to_hit;
        int          len;
        logic [31:0] want_rd;
        mapped = (addr < 32'h40);
        if (!mapped || (TO_EN && (lat + 1 > int'(TO)))) begin
            to_hit = 1'b1;
            len    = int'(TO);
        end else begin
            to_hit = 1'b0;
            len    = lat + 1;
        end
        want_rd = (to_hit || wr) ? 32'h0 : mem[addr[5:2]];

        chk("idle_ready", {31'd0, bif.req_ready}, 32'd1);
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        bif.req_mask  = mask;
        @(posedge clk); #1;
        rsp_drive = 1'b0;
        if (!keep) begin
            bif.req_valid = 1'b0;
        end else begin
            bif.req_write = ~wr;
            bif.req_addr  = $urandom;
            bif.req_wdata = $urandom;
            bif.req_mask  = 4'($urandom);
        end
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            chk("acc_rd", {31'd0, bif.rd_bus}, {31'd0, !wr});
            chk("acc_wr", {31'd0, bif.wr_bus}, {31'd0, wr});
            chk("acc_addr", bif.addr_bus, addr);
            chk("acc_mask", {28'd0, bif.data_mask_bus}, {28'd0, mask});
            chk("acc_ready", {31'd0, bif.req_ready}, 32'd0);
            chk("acc_rv", {31'd0, bif.resp_valid}, 32'd0);
            chk("acc_hold", bif.resp_rdata, exp_rdata);
            if (wr) chk("acc_wdata", data_bus, wdata);
            if (!to_hit && n == lat) begin
                bif.fc_bus = 1'b1;
                if (!wr) begin
                    rsp_data  = mem[addr[5:2]];
                    rsp_drive = 1'b1;
                end
            end
            @(posedge clk); #1;
            bif.fc_bus = 1'b0;
            rsp_drive  = 1'b0;
        end
        if (!to_hit && wr) mem[addr[5:2]] = merge(mem[addr[5:2]], wdata, mask);
        exp_rdata = want_rd;
        exp_err   = {31'd0, to_hit};
        exp_pulse++;
        rsp_data  = 32'h0;
        rsp_drive = 1'b1;
        @(negedge clk);
        chk("rel_rv", {31'd0, bif.resp_valid}, 32'd1);
        chk("rel_rdata", bif.resp_rdata, exp_rdata);
        chk("rel_err", {31'd0, bif.resp_err}, exp_err);
        chk("rel_strobes", {30'd0, bif.rd_bus, bif.wr_bus}, 32'd0);
        chk("rel_addr", bif.addr_bus, 32'h0);
        chk("rel_mask", {28'd0, bif.data_mask_bus}, 32'd0);
        chk("rel_data_free", data_bus, 32'h0);
        chk("rel_ready", {31'd0, bif.req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_rv", {31'd0, bif.resp_valid}, 32'd0);
        chk("idle_hold", bif.resp_rdata, exp_rdata);
        chk("idle_strobes", {30'd0, bif.rd_bus, bif.wr_bus}, 32'd0);
        chk("idle_data_free", data_bus, 32'h0);
    endtask

    // Reset lands in the 2nd ACCESS cycle of a write; nothing may complete.
    task automatic reset_mid_write();
        chk("rw_ready", {31'd0, bif.req_ready}, 32'd1);
        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_addr  = 32'h20;
        bif.req_wdata = 32'hDEAD_BEEF;
        bif.req_mask  = 4'hF;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        rsp_drive     = 1'b0;
        @(negedge clk);
        chk("rw_wr_on", {31'd0, bif.wr_bus}, 32'd1);
        chk("rw_data_on", data_bus, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        rst       = 1'b1;
        rsp_data  = 32'h0;
        rsp_drive = 1'b1;
        #1;
        chk("rw_wr_off", {31'd0, bif.wr_bus}, 32'd0);
        chk("rw_rd_off", {31'd0, bif.rd_bus}, 32'd0);
        chk("rw_addr_off", bif.addr_bus, 32'h0);
        chk("rw_data_free", data_bus, 32'h0);
        chk("rw_ready_rst", {31'd0, bif.req_ready}, 32'd0);
        chk("rw_rv_rst", {31'd0, bif.resp_valid}, 32'd0);
        @(negedge clk);
        exp_rdata = 32'h0;
        exp_err   = 32'h0;
        chk("rw_rdata_rst", bif.resp_rdata, exp_rdata);
        chk("rw_err_rst", {31'd0, bif.resp_err}, exp_err);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rw_ready_after", {31'd0, bif.req_ready}, 32'd1);
        @(negedge clk);
        chk("rw_rv_after", {31'd0, bif.resp_valid}, 32'd0);
        chk("rw_wr_after", {31'd0, bif.wr_bus}, 32'd0);
    endtask

    initial begin
        logic        r_wr;
        logic [31:0] r_addr;
        rst           = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = 32'h0;
        bif.req_wdata = 32'h0;
        bif.req_mask  = 4'h0;
        bif.fc_bus    = 1'b0;
        rsp_drive     = 1'b1;
        rsp_data      = 32'h0;
        exp_rdata     = 32'h0;
        exp_err       = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bif.req_ready}, 32'd0);
        chk("rst_rv", {31'd0, bif.resp_valid}, 32'd0);
        chk("rst_rdata", bif.resp_rdata, 32'h0);
        chk("rst_err", {31'd0, bif.resp_err}, 32'd0);
        chk("rst_strobes", {30'd0, bif.rd_bus, bif.wr_bus}, 32'd0);
        chk("rst_addr", bif.addr_bus, 32'h0);
        chk("rst_mask", {28'd0, bif.data_mask_bus}, 32'd0);
        chk("rst_data_free", data_bus, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, bif.req_ready}, 32'd1);
        @(negedge clk);

        mem[1] = 32'h1234_5678;
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 2, 1'b0);
        run_txn(1'b1, 32'h0, 32'h0000_00FF, 4'h1, 1, 1'b0);
        run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
        run_txn(1'b0, 32'h8, 32'h0, 4'hF, 1, 1'b1);
        run_txn(1'b0, 32'hC, 32'h0, 4'hF, 0, 1'b0);
        run_txn(1'b0, 32'h14, 32'h0, 4'hF, int'(TO) - 1, 1'b0);
        run_txn(1'b0, 32'h18, 32'h0, 4'hF, int'(TO) + 3, 1'b0);
`ifdef BUS_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 1'b0);
        run_txn(1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'h3, 0, 1'b0);
`endif
        reset_mid_write();

        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom);
            r_addr = {26'd0, 4'($urandom), 2'b00};
            if (TO_EN && ($urandom_range(0, 5) == 0)) r_addr = 32'h100 + r_addr;
            run_txn(r_wr, r_addr, $urandom | 32'h1, 4'($urandom_range(1, 15)),
                    $urandom_range(0, 9), 1'($urandom));
        end
        bif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pulse_count", n_pulse, exp_pulse);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
